// File: rtl/dmem_lsu_pkg.sv
// Shared constants, state encoding and access-legality helper for the data-memory LSU.
package dmem_lsu_pkg;

  localparam int DMEM_SIZE_DEF = 128;
  localparam int TIMEOUT_DEF   = 16;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Legal = in range, naturally aligned, known size code, and no unsigned store.
  function automatic logic lsu_legal(input logic st, input logic [2:0] f3,
                                     input logic [31:0] a, input int unsigned size);
    logic ok;
    ok = (a < 32'(size));
    case (f3)
      F3_B:         ;
      F3_H:         if (a[0]) ok = 1'b0;
      F3_W:         if (a[1:0] != 2'b00) ok = 1'b0;
      F3_BU, F3_HU: if (st) ok = 1'b0;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction / extension for loads.
module lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] drdata_i,
  output logic [3:0]  we_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] w_shift;

  assign w_shift = drdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    we_o    = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = 32'h0;
    case (funct3_i)
      F3_B: begin
        we_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{w_shift[7]}}, w_shift[7:0]};
      end
      F3_H: begin
        we_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{w_shift[15]}}, w_shift[15:0]};
      end
      F3_W: begin
        we_o    = 4'b1111;
        rdata_o = w_shift;
      end
      F3_BU: rdata_o = {24'h0, w_shift[7:0]};
      F3_HU: rdata_o = {16'h0, w_shift[15:0]};
      default: ;
    endcase
    // Loads never write; stores return zero as their result.
    if (!store_i) we_o = 4'b0000;
    else          rdata_o = 32'h0;
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: IDLE/WAIT/DONE handshake to a word-wide data memory.
// Optional WAIT abort counter enabled by defining DMEM_LSU_TIMEOUT_EN.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int DMEM_SIZE = DMEM_SIZE_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        busy_o,
  output logic [31:0] daddr_o,
  output logic [31:0] dwdata_o,
  output logic [3:0]  dwe_o,
  output logic        dce_o,
  input  logic [31:0] drdata_i,
  input  logic        dvalid_i
);

  if (TIMEOUT < 1 || DMEM_SIZE < 4) begin : g_bad_param
    $error("dmem_lsu: TIMEOUT must be >= 1 and DMEM_SIZE >= 4");
  end

  state_t      r_state;
  logic        r_store;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_legal;
  logic        w_wait;
  logic        w_tmo;
  logic [3:0]  w_we;
  logic [31:0] w_dwdata;
  logic [31:0] w_rdata;

  assign w_legal = lsu_legal(store_i, funct3_i, addr_i, DMEM_SIZE);
  assign w_wait  = (r_state == S_WAIT);

  lsu_align u_align (
    .store_i   (r_store),
    .funct3_i  (r_f3),
    .addr_lo_i (r_addr[1:0]),
    .wdata_i   (r_wdata),
    .drdata_i  (drdata_i),
    .we_o      (w_we),
    .wdata_o   (w_dwdata),
    .rdata_o   (w_rdata)
  );

`ifdef DMEM_LSU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tcnt;

  // Counts completed WAIT cycles; abort fires on the TIMEOUT-th one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_tcnt <= '0;
    else if (w_wait) r_tcnt <= r_tcnt + 1'b1;
    else             r_tcnt <= '0;
  end
  assign w_tmo = w_wait && (r_tcnt == TW'(TIMEOUT - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_store <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_i) begin
          r_store <= store_i;
          r_f3    <= funct3_i;
          r_addr  <= addr_i;
          r_wdata <= wdata_i;
          if (w_legal) begin
            r_state <= S_WAIT;
          end else begin
            r_state <= S_DONE;
            r_err   <= 1'b1;
            r_rdata <= 32'h0;
          end
        end
        S_WAIT: if (dvalid_i) begin
          r_state <= S_DONE;
          r_rdata <= w_rdata;
          r_err   <= 1'b0;
        end else if (w_tmo) begin
          r_state <= S_DONE;
          r_rdata <= 32'h0;
          r_err   <= 1'b1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory-side strobes are qualified by WAIT so nothing leaks while idle or on errors.
  assign dce_o    = w_wait;
  assign daddr_o  = w_wait ? {r_addr[31:2], 2'b00} : 32'h0;
  assign dwe_o    = w_wait ? w_we : 4'b0000;
  assign dwdata_o = w_dwdata;
  assign busy_o   = (r_state != S_IDLE);
  assign done_o   = (r_state == S_DONE);
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed vector bench for dmem_lsu with a byte-array memory model and variable wait states.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_i = 1'b0, store_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] addr_i = '0, wdata_i = '0, drdata_i = '0;
  logic        dvalid_i = 1'b0;
  logic [31:0] rdata_o, daddr_o, dwdata_o;
  logic        done_o, err_o, busy_o, dce_o;
  logic [3:0]  dwe_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [0:127];

  always #5 clk = ~clk;

  dmem_lsu dut (
    .clk(clk), .reset(reset), .req_i(req_i), .store_i(store_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o),
    .busy_o(busy_o), .daddr_o(daddr_o), .dwdata_o(dwdata_o), .dwe_o(dwe_o), .dce_o(dce_o),
    .drdata_i(drdata_i), .dvalid_i(dvalid_i)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          lat;
    logic        ill;
    logic [31:0] exp_rd;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rdw(input logic [31:0] a);
    int b;
    b = int'(a) & 124;
    return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
  endfunction

  // One access: dvalid_i stays low for 'lat' WAIT cycles, then rises.
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int lat,
                        output logic [31:0] rd, output logic er, output int dce_cyc,
                        output int lat_cyc, output logic [3:0] we_s,
                        output logic [31:0] wdat_s, output logic [31:0] daddr_s);
    int waitc;
    int b;
    @(negedge clk);
    req_i = 1'b1; store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd; dvalid_i = 1'b0;
    @(negedge clk);
    req_i = 1'b0;
    lat_cyc = 1; dce_cyc = 0; waitc = 0; we_s = '0; wdat_s = '0; daddr_s = '0;
    while (!done_o && lat_cyc < 200) begin
      if (dce_o) begin
        dce_cyc++; waitc++;
        we_s = dwe_o; wdat_s = dwdata_o; daddr_s = daddr_o;
        drdata_i = rdw(daddr_o);
        dvalid_i = (waitc > lat);
        if (dvalid_i) begin
          b = int'(daddr_o) & 124;
          for (int k = 0; k < 4; k++)
            if (dwe_o[k]) mem[b+k] = dwdata_o[8*k +: 8];
        end
      end else begin
        dvalid_i = 1'b0;
      end
      @(negedge clk);
      lat_cyc++;
    end
    dvalid_i = 1'b0;
    if (!done_o) begin
      errors++; checks++;
      $display("FAIL timeout: got no done_o expected done_o within 200 cycles");
    end
    rd = rdata_o; er = err_o;
  endtask

  initial begin
    vec_t v[$];
    logic [31:0] rd, wdat_s, daddr_s;
    logic [3:0]  we_s;
    logic        er, saw_done;
    int          dce_cyc, lat_cyc;

    for (int i = 0; i < 128; i++) mem[i] = 8'h00;

    v.push_back(vec_t'{1'b1, F3_W,  32'h10, 32'hDEADBEEF, 1, 1'b0, 32'h0,        4'b1111, 32'hDEADBEEF});
    v.push_back(vec_t'{1'b0, F3_W,  32'h10, 32'h0,        1, 1'b0, 32'hDEADBEEF, 4'b0000, 32'h0});
    v.push_back(vec_t'{1'b1, F3_B,  32'h13, 32'h00000080, 2, 1'b0, 32'h0,        4'b1000, 32'h80808080});
    v.push_back(vec_t'{1'b0, F3_B,  32'h13, 32'h0,        1, 1'b0, 32'hFFFFFF80, 4'b0000, 32'h0});
    v.push_back(vec_t'{1'b0, F3_BU, 32'h13, 32'h0,        1, 1'b0, 32'h00000080, 4'b0000, 32'h0});
    v.push_back(vec_t'{1'b1, F3_H,  32'h12, 32'h00008001, 1, 1'b0, 32'h0,        4'b1100, 32'h80018001});
    v.push_back(vec_t'{1'b0, F3_H,  32'h12, 32'h0,        1, 1'b0, 32'hFFFF8001, 4'b0000, 32'h0});
    v.push_back(vec_t'{1'b0, F3_HU, 32'h12, 32'h0,        1, 1'b0, 32'h00008001, 4'b0000, 32'h0});
    v.push_back(vec_t'{1'b0, F3_H,  32'h10, 32'h0,        1, 1'b0, 32'hFFFFBEEF, 4'b0000, 32'h0});
    v.push_back(vec_t'{1'b0, F3_B,  32'h11, 32'h0,        1, 1'b0, 32'hFFFFFFBE, 4'b0000, 32'h0});
    v.push_back(vec_t'{1'b0, F3_W,  32'h10, 32'h0,        3, 1'b0, 32'h8001BEEF, 4'b0000, 32'h0});
    v.push_back(vec_t'{1'b1, F3_B,  32'h11, 32'hFFFFFF5A, 1, 1'b0, 32'h0,        4'b0010, 32'h5A5A5A5A});
    v.push_back(vec_t'{1'b0, F3_W,  32'h10, 32'h0,        1, 1'b0, 32'h80015AEF, 4'b0000, 32'h0});
    v.push_back(vec_t'{1'b1, F3_W,  32'h7C, 32'h0BADF00D, 1, 1'b0, 32'h0,        4'b1111, 32'h0BADF00D});
    v.push_back(vec_t'{1'b0, F3_B,  32'h7F, 32'h0,        1, 1'b0, 32'h0000000B, 4'b0000, 32'h0});
    v.push_back(vec_t'{1'b1, F3_H,  32'h7E, 32'hFFFF1234, 1, 1'b0, 32'h0,        4'b1100, 32'h12341234});
    v.push_back(vec_t'{1'b0, F3_H,  32'h7E, 32'h0,        1, 1'b0, 32'h00001234, 4'b0000, 32'h0});
    v.push_back(vec_t'{1'b0, F3_BU, 32'h7C, 32'h0,        1, 1'b0, 32'h0000000D, 4'b0000, 32'h0});
    v.push_back(vec_t'{1'b0, F3_H,  32'h11, 32'h0,        1, 1'b1, 32'h0,        4'b0000, 32'h0});
    v.push_back(vec_t'{1'b0, F3_W,  32'h80, 32'h0,        1, 1'b1, 32'h0,        4'b0000, 32'h0});
    v.push_back(vec_t'{1'b0, F3_W,  32'h12, 32'h0,        1, 1'b1, 32'h0,        4'b0000, 32'h0});
    v.push_back(vec_t'{1'b1, F3_BU, 32'h00, 32'h11,       1, 1'b1, 32'h0,        4'b0000, 32'h0});
    v.push_back(vec_t'{1'b0, 3'b011, 32'h00, 32'h0,       1, 1'b1, 32'h0,        4'b0000, 32'h0});
    v.push_back(vec_t'{1'b0, F3_W,  32'h10, 32'h0,        1, 1'b0, 32'h80015AEF, 4'b0000, 32'h0});

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_dce", {31'h0, dce_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_done", {31'h0, done_o}, 32'h0);
    chk("rst_err", {31'h0, err_o}, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_daddr", daddr_o, 32'h0);
    chk("rst_dwe", {28'h0, dwe_o}, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < v.size(); i++) begin
      access(v[i].st, v[i].f3, v[i].addr, v[i].wd, v[i].lat, rd, er, dce_cyc, lat_cyc,
             we_s, wdat_s, daddr_s);
      chk($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, v[i].ill});
      chk($sformatf("v%0d_lat", i), lat_cyc, v[i].ill ? 1 : v[i].lat + 2);
      chk($sformatf("v%0d_dce_cycles", i), dce_cyc, v[i].ill ? 0 : v[i].lat + 1);
      if (!v[i].ill) begin
        chk($sformatf("v%0d_rdata", i), rd, v[i].exp_rd);
        chk($sformatf("v%0d_dwe", i), {28'h0, we_s}, {28'h0, v[i].exp_we});
        chk($sformatf("v%0d_daddr", i), daddr_s, v[i].addr & 32'hFFFF_FFFC);
        if (v[i].st) chk($sformatf("v%0d_dwdata", i), wdat_s, v[i].exp_wdat);
      end
    end

    // Results hold while idle
    repeat (4) @(negedge clk);
    chk("hold_rdata", rdata_o, 32'h80015AEF);
    chk("hold_err", {31'h0, err_o}, 32'h0);
    chk("hold_busy", {31'h0, busy_o}, 32'h0);

    // Reset mid-WAIT aborts asynchronously with no done pulse
    @(negedge clk);
    req_i = 1'b1; store_i = 1'b0; funct3_i = F3_W; addr_i = 32'h10;
    @(negedge clk);
    req_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_dce", {31'h0, dce_o}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("arst_dce", {31'h0, dce_o}, 32'h0);
    chk("arst_busy", {31'h0, busy_o}, 32'h0);
    chk("arst_rdata", rdata_o, 32'h0);
    chk("arst_daddr", daddr_o, 32'h0);
    saw_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      saw_done |= done_o;
    end
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      saw_done |= done_o;
    end
    chk("arst_no_done", {31'h0, saw_done}, 32'h0);
    access(1'b0, F3_W, 32'h10, 32'h0, 1, rd, er, dce_cyc, lat_cyc, we_s, wdat_s, daddr_s);
    chk("post_rst_rdata", rd, 32'h80015AEF);
    chk("post_rst_lat", lat_cyc, 3);

    // Stuck / slow memory
`ifdef DMEM_LSU_TIMEOUT_EN
    access(1'b0, F3_W, 32'h10, 32'h0, 1000, rd, er, dce_cyc, lat_cyc, we_s, wdat_s, daddr_s);
    chk("tmo_err", {31'h0, er}, 32'h1);
    chk("tmo_dce_cycles", dce_cyc, 16);
    chk("tmo_lat", lat_cyc, 17);
`else
    access(1'b0, F3_W, 32'h10, 32'h0, 40, rd, er, dce_cyc, lat_cyc, we_s, wdat_s, daddr_s);
    chk("slow_err", {31'h0, er}, 32'h0);
    chk("slow_dce_cycles", dce_cyc, 41);
    chk("slow_rdata", rd, 32'h80015AEF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 The block SHALL have parameter DMEM_SIZE, default 128, meaning data memory size in bytes; legal addresses are 0..DMEM_SIZE-1.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of WAIT cycles before an abort.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, meaning asynchronous active-low reset.
REQ-005 The block SHALL have port req_i, input, 1 bit, meaning the core requests an access this cycle.
REQ-006 The block SHALL have port store_i, input, 1 bit, meaning 1 for store, 0 for load.
REQ-007 The block SHALL have port funct3_i, input, 3 bits, meaning access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 The block SHALL have port addr_i, input, 32 bits, meaning the byte address.
REQ-009 The block SHALL have port wdata_i, input, 32 bits, meaning store data, right-aligned.
REQ-010 The block SHALL have port rdata_o, output, 32 bits, meaning load result, aligned and extended.
REQ-011 The block SHALL have port done_o, output, 1 bit, meaning a one-cycle completion pulse.
REQ-012 The block SHALL have port err_o, output, 1 bit, meaning the completing access failed; valid only with done_o.
REQ-013 The block SHALL have port busy_o, output, 1 bit, meaning the block is not in IDLE.
REQ-014 The block SHALL have port daddr_o, output, 32 bits, meaning the memory address, word-aligned.
REQ-015 The block SHALL have port dwdata_o, output, 32 bits, meaning memory write data, lane-positioned.
REQ-016 The block SHALL have port dwe_o, output, 4 bits, meaning per-byte write enables.
REQ-017 The block SHALL have port dce_o, output, 1 bit, meaning memory chip enable.
REQ-018 The block SHALL have port drdata_i, input, 32 bits, meaning memory read word.
REQ-019 The block SHALL have port dvalid_i, input, 1 bit, meaning memory access completes this cycle.

Function
REQ-020 The FSM SHALL have states IDLE, WAIT and DONE; on req_i in IDLE it SHALL register store_i/funct3_i/addr_i/wdata_i and go to WAIT, or go to DONE with err flag set if the access is illegal.
REQ-021 Illegal accesses SHALL be: misalignment (H with addr[0]=1, W with addr[1:0]!=0), addr_i >= DMEM_SIZE, funct3 outside the five listed codes, and store with 100/101; an illegal access SHALL never assert dce_o.
REQ-022 In WAIT only, dce_o SHALL be 1, daddr_o SHALL be {addr[31:2],2'b00}, and dwe_o SHALL be 0001<<addr[1:0] (B), 0011<<addr[1:0] (H), 1111 (W), or 0000 for loads; outside WAIT dce_o, dwe_o and daddr_o SHALL be 0.
REQ-023 dwdata_o SHALL be {4{wdata[7:0]}} for B, {2{wdata[15:0]}} for H, and wdata for W.
REQ-024 In WAIT with dvalid_i=1, the block SHALL latch rdata = (drdata_i >> 8*addr[1:0]) sign-extended (B/H) or zero-extended (BU/HU), or zero for stores, and go to DONE.
REQ-025 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE; req_i SHALL be ignored outside IDLE.
REQ-026 Minimum latency SHALL be: request accepted at edge N, done_o high in the cycle following edge N+2; rdata_o and err_o SHALL hold their values until the next done_o.

Reset
REQ-027 reset low SHALL immediately force IDLE, dce_o=0, dwe_o=0, done_o=0, err_o=0, busy_o=0, rdata_o=0 and daddr_o=0, aborting any access mid-operation.

Configuration
REQ-028 With macro DMEM_LSU_TIMEOUT_EN defined, a WAIT lasting TIMEOUT cycles without dvalid_i SHALL go to DONE with err_o=1; without the macro, WAIT SHALL persist until dvalid_i with no counter present.

Structure
REQ-029 Package dmem_lsu_pkg SHALL hold the funct3 constants, the state typedef, and the default DMEM_SIZE/TIMEOUT values.
REQ-030 Sub-module lsu_align SHALL hold the combinational lane steering (dwe/dwdata) and load extraction/extension.

Verification
REQ-031 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> dwe_o=1111, and the load returns 0xDEADBEEF with err_o=0.
REQ-032 SB addr 0x13 data 0x80, then LB 0x13 -> dwe_o=1000, dwdata_o=0x80808080, LB returns 0xFFFFFF80, and LBU returns 0x00000080.
REQ-033 LH addr 0x11 -> done_o after one cycle, err_o=1, dce_o never 1; LW addr 0x80 -> err_o=1.
REQ-034 dvalid_i held low for 3 cycles then high -> dce_o stays 1 for 4 cycles and done_o follows one cycle later; with DMEM_LSU_TIMEOUT_EN and dvalid_i stuck low -> err_o=1 after 16 WAIT cycles.
REQ-035 reset asserted during WAIT -> dce_o=0 asynchronously, no done_o pulse, and the next request is accepted normally.
